mc_control: RTL

Multi-cycle control unit for the 16-bit MIPS datapath, successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, so a single ALU and a single unified memory port can be shared across instructions. It also adds a memory request/acknowledge handshake with wait states, two new opcodes (bne, halt), illegal-opcode detection and a parametrised opcode width. It sits between the instruction register and all datapath mux/enable inputs.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_decode.sv | 42 ++++
 rtl/mc_control.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared opcode map, FSM state encoding and datapath select encodings for the
// multi-cycle MIPS control unit.
package mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLI  = 4'd1;
  localparam logic [3:0] OP_J    = 4'd2;
  localparam logic [3:0] OP_JAL  = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_SHIFT = 2'b10;
  localparam logic [1:0] ALU_ADDI  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier; any set bit above bit 3 marks the opcode
// illegal regardless of the low nibble.
module mc_decode
  import mc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  output logic           is_rtype,
  output logic           is_mem,
  output logic           is_branch,
  output logic           is_jump,
  output logic           is_illegal
);

  logic [OPW-1:0] hi;
  logic [3:0]     lo;

  assign hi = op >> 4;
  assign lo = op[3:0];

  always_comb begin
    is_rtype   = 1'b0;
    is_mem     = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    if (|hi) begin
      is_illegal = 1'b1;
    end else begin
      case (lo)
        OP_ADD, OP_SLI, OP_ADDI: is_rtype  = 1'b1;
        OP_LW, OP_SW:            is_mem    = 1'b1;
        OP_BEQ, OP_BNE:          is_branch = 1'b1;
        OP_J, OP_JAL:            is_jump   = 1'b1;
        OP_HALT:                 ;
        default:                 is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU
// and a single handshaked memory port.
module mc_control
  import mc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     reg_dst,
  output logic [1:0]     mem_to_reg,
  output logic           reg_write,
  output logic           branch,
  output logic           branch_ne,
  output logic           sign_or_zero,
  output logic           illegal,
  output logic           instr_done,
  output logic           halted
);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] dec_op;
  logic [3:0]     op_lo;
  logic           is_rtype, is_mem, is_branch, is_jump, is_illegal;

  // DECODE classifies the live IR field; later states only look at op_q.
  assign dec_op = (state == DECODE) ? opcode : op_q;
  assign op_lo  = dec_op[3:0];

  mc_decode #(.OPW(OPW)) u_decode (
    .op        (dec_op),
    .is_rtype  (is_rtype),
    .is_mem    (is_mem),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_illegal(is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op_q  <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ack) state <= DECODE;
        DECODE: begin
          op_q <= opcode;
          if (is_illegal)                         state <= FETCH;
          else if (is_jump && (op_lo == OP_J))    state <= FETCH;
          else if (is_jump)                       state <= WB;
          else if (op_lo == OP_HALT)              state <= HALT;
          else                                    state <= EXEC;
        end
        EXEC: begin
          if (is_mem)         state <= MEM;
          else if (is_branch) state <= FETCH;
          else if (is_rtype)  state <= WB;
          else                state <= FETCH;
        end
        MEM: if (mem_ack) state <= (op_lo == OP_SW) ? FETCH : WB;
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are decoded from state; reset masks them so nothing fires in that cycle.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RT;
    alu_op       = ALU_ADD;
    reg_dst      = RD_RT;
    mem_to_reg   = MTR_ALU;
    reg_write    = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    sign_or_zero = 1'b1;
    illegal      = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_TWO;
          ir_write  = mem_ack;
          pc_write  = mem_ack;
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          if (is_illegal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end else if (is_jump && (op_lo == OP_J)) begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
          end
        end
        EXEC: begin
          alu_src_a = 1'b1;
          case (op_lo)
            OP_SLI: begin
              alu_src_b    = SRCB_IMM;
              alu_op       = ALU_SHIFT;
              sign_or_zero = 1'b0;
            end
            OP_ADDI, OP_LW, OP_SW: begin
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_ADDI;
            end
            OP_BEQ, OP_BNE: begin
              alu_op     = ALU_SUB;
              branch     = 1'b1;
              branch_ne  = (op_lo == OP_BNE);
              pc_src     = PC_ALUOUT;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_we     = (op_lo == OP_SW);
          instr_done = mem_ack && (op_lo == OP_SW);
        end
        WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          case (op_lo)
            OP_ADD: reg_dst = RD_RD;
            OP_LW:  mem_to_reg = MTR_MEM;
            OP_JAL: begin
              reg_dst    = RD_RA;
              mem_to_reg = MTR_PC;
              pc_write   = 1'b1;
              pc_src     = PC_JUMP;
            end
            default: ;
          endcase
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
